// File: rtl/ctrl_unit_fsm_if.sv
// Handshake bundle between the multi-cycle control unit and the IR/datapath/memory side.
// The control unit drives the strobes (master); the datapath supplies opcode, flags and mem_ready (slave).
interface ctrl_unit_fsm_if #(
    parameter int OPW = 6
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           ir_load;
    logic           pc_inc;
    logic           pc_load;
    logic [2:0]     alu_op;
    logic           reg_we;
    logic           mem_rd;
    logic           mem_wr;
    logic           illegal_op;
    logic           bus_err;
    logic           halted;
    logic [2:0]     state;

    modport master (
        input  opcode, zero, mem_ready,
        output ir_load, pc_inc, pc_load, alu_op, reg_we,
               mem_rd, mem_wr, illegal_op, bus_err, halted, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ir_load, pc_inc, pc_load, alu_op, reg_we,
               mem_rd, mem_wr, illegal_op, bus_err, halted, state
    );
endinterface

// File: rtl/ctrl_unit_fsm.sv
// Multi-cycle instruction control unit: fetch/decode/exec/mem/writeback sequencing with a
// memory-wait timeout. Outputs are decoded combinationally from the registered state.
module ctrl_unit_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPW         = 6
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_unit_fsm_if.master   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [OPW-1:0] OP_NOP   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_AND   = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_OR    = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_STORE = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_BRZ   = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(6'b100001);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_LOAD, C_STORE, C_BRZ, C_JMP, C_HALT, C_ILL
    } op_class_t;

    function automatic op_class_t classify(input logic [OPW-1:0] op);
        op_class_t c;
        case (op)
            OP_NOP:                         c = C_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  c = C_ALU;
            OP_LOAD:                        c = C_LOAD;
            OP_STORE:                       c = C_STORE;
            OP_BRZ:                         c = C_BRZ;
            OP_JMP:                         c = C_JMP;
            OP_HALT:                        c = C_HALT;
            default:                        c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] alu_code(input logic [OPW-1:0] op);
        logic [2:0] a;
        case (op)
            OP_SUB, OP_BRZ: a = 3'b001;
            OP_AND:         a = 3'b010;
            OP_OR:          a = 3'b011;
            default:        a = 3'b000;
        endcase
        return a;
    endfunction

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    op_class_t  cls;
    logic       wait_st;
    logic       timed_out;

    assign cls       = classify(bus.opcode);
    assign wait_st   = (state_q == S_FETCH) || (state_q == S_MEM);
    // mem_ready arriving on the limit cycle wins over the timeout
    assign timed_out = wait_st && !bus.mem_ready && (cnt_q == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (timed_out) state_d = S_IDLE;
            end
            S_DECODE: begin
                case (cls)
                    C_ALU, C_LOAD, C_STORE, C_BRZ: state_d = S_EXEC;
                    C_HALT:                        state_d = S_HALT;
                    default:                       state_d = S_FETCH;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_ALU:          state_d = S_WB;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready)  state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
                else if (timed_out) state_d = S_IDLE;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Wait counter restarts on every state change, so each FETCH/MEM visit gets a fresh budget
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (wait_st && !bus.mem_ready)
            cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        bus.ir_load    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.alu_op     = 3'b000;
        bus.reg_we     = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.illegal_op = 1'b0;
        bus.bus_err    = 1'b0;
        bus.halted     = 1'b0;
        bus.state      = state_q;
        case (state_q)
            S_FETCH: begin
                bus.mem_rd  = 1'b1;
                bus.ir_load = bus.mem_ready;
                bus.pc_inc  = bus.mem_ready;
                bus.bus_err = timed_out;
            end
            S_DECODE: begin
                bus.pc_load    = (cls == C_JMP);
                bus.illegal_op = (cls == C_ILL);
            end
            S_EXEC: begin
                bus.alu_op  = alu_code(bus.opcode);
                bus.pc_load = (cls == C_BRZ) && bus.zero;
            end
            S_MEM: begin
                bus.mem_rd  = (cls == C_LOAD);
                bus.mem_wr  = (cls != C_LOAD);
                bus.bus_err = timed_out;
            end
            S_WB:    bus.reg_we = 1'b1;
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// Self-checking bench for ctrl_unit_fsm: directed vector table, hand-written corner sequences,
// and randomized instruction streams checked against an instruction-level trace model.
module tb_ctrl_unit_fsm;
    localparam int TO = 15;

    // Expected-output packing: {state[2:0], ir_load, pc_inc, pc_load, alu_op[2:0],
    //                           reg_we, mem_rd, mem_wr, illegal_op, bus_err, halted}
    localparam logic [14:0] F_IRL = 15'h0800;
    localparam logic [14:0] F_PCI = 15'h0400;
    localparam logic [14:0] F_PCL = 15'h0200;
    localparam logic [14:0] F_WE  = 15'h0020;
    localparam logic [14:0] F_RD  = 15'h0010;
    localparam logic [14:0] F_WR  = 15'h0008;
    localparam logic [14:0] F_ILL = 15'h0004;
    localparam logic [14:0] F_BE  = 15'h0002;
    localparam logic [14:0] F_HL  = 15'h0001;

    localparam logic [5:0] OP_NOP = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02, OP_AND = 6'h03,
                           OP_OR  = 6'h04, OP_LD  = 6'h10, OP_ST  = 6'h11, OP_BRZ = 6'h20,
                           OP_JMP = 6'h21, OP_HLT = 6'h3F;

    typedef struct {
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [14:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    vec_t q[$];

    ctrl_unit_fsm_if #(.OPW(6)) bus ();

    ctrl_unit_fsm #(.MEM_TIMEOUT(TO), .OPW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] S(input logic [2:0] s);
        return {s, 12'h000};
    endfunction

    function automatic logic [14:0] A(input logic [2:0] a);
        return {6'b000000, a, 6'b000000};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST, OP_BRZ, OP_JMP, OP_HLT};
    endfunction

    task automatic step(input logic r, input logic mr, input logic z, input logic [5:0] op,
                        input logic [14:0] exp, input string name);
        logic [14:0] got;
        @(negedge clk);
        rst           = r;
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.opcode    = op;
        #1;
        got = {bus.state, bus.ir_load, bus.pc_inc, bus.pc_load, bus.alu_op, bus.reg_we,
               bus.mem_rd, bus.mem_wr, bus.illegal_op, bus.bus_err, bus.halted};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d op=%h mr=%b got=%h expected=%h", name, cyc, op, mr, got, exp);
        end
        cyc++;
    endtask

    task automatic push(input logic mr, input logic z, input logic [5:0] op, input logic [14:0] exp);
        vec_t v;
        v.mr = mr; v.z = z; v.op = op; v.exp = exp;
        q.push_back(v);
    endtask

    task automatic run_q(input string name);
        foreach (q[i]) step(1'b1, q[i].mr, q[i].z, q[i].op, q[i].exp, name);
        q.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 6'h00, 15'h0000, "reset");
    endtask

    // Instruction-level trace model: one call emits every cycle of one instruction, starting in FETCH.
    // wf / wm = number of cycles mem_ready stays low before it rises in FETCH / MEM.
    task automatic gen(input logic [5:0] op, input int wf, input int wm, input logic z);
        for (int k = 0; k <= TO; k++) begin
            if (k == wf) begin
                push(1'b1, z, op, S(3'd1) | F_RD | F_IRL | F_PCI);
                break;
            end
            if (k == TO) begin
                push(1'b0, z, op, S(3'd1) | F_RD | F_BE);
                push(rb(), z, op, S(3'd0));
                return;
            end
            push(1'b0, z, op, S(3'd1) | F_RD);
        end
        if (!is_legal(op)) begin
            push(rb(), z, op, S(3'd2) | F_ILL);
        end else if (op == OP_NOP) begin
            push(rb(), z, op, S(3'd2));
        end else if (op == OP_JMP) begin
            push(rb(), z, op, S(3'd2) | F_PCL);
        end else if (op == OP_BRZ) begin
            push(rb(), z, op, S(3'd2));
            push(rb(), z, op, S(3'd3) | A(3'd1) | (z ? F_PCL : 15'h0000));
        end else if (op >= OP_ADD && op <= OP_OR) begin
            push(rb(), z, op, S(3'd2));
            push(rb(), z, op, S(3'd3) | A(3'(op - 6'd1)));
            push(rb(), z, op, S(3'd5) | F_WE);
        end else begin
            logic [14:0] acc;
            acc = (op == OP_LD) ? F_RD : F_WR;
            push(rb(), z, op, S(3'd2));
            push(rb(), z, op, S(3'd3) | A(3'd0));
            for (int k = 0; k <= TO; k++) begin
                if (k == wm) begin
                    push(1'b1, z, op, S(3'd4) | acc);
                    if (op == OP_LD) push(rb(), z, op, S(3'd5) | F_WE);
                    break;
                end
                if (k == TO) begin
                    push(1'b0, z, op, S(3'd4) | acc | F_BE);
                    push(rb(), z, op, S(3'd0));
                    break;
                end
                push(1'b0, z, op, S(3'd4) | acc);
            end
        end
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(TO - 2, TO + 2));
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] o;
        case ($urandom_range(0, 11))
            0: o = OP_NOP;  1: o = OP_ADD;  2: o = OP_SUB;  3: o = OP_AND;
            4: o = OP_OR;   5: o = OP_LD;   6: o = OP_ST;   7: o = OP_BRZ;
            8: o = OP_JMP;
            default: begin
                o = 6'($urandom_range(0, 63));
                while (is_legal(o)) o = 6'($urandom_range(0, 63));
            end
        endcase
        return o;
    endfunction

    initial begin
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.opcode    = 6'h00;

        do_reset();

        // Directed vector table, expectations written out by hand
        push(1'b0, 1'b0, OP_NOP, S(3'd0));                               // IDLE after release
        push(1'b1, 1'b0, OP_ADD, S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, OP_ADD, S(3'd2));
        push(1'b1, 1'b0, OP_ADD, S(3'd3) | A(3'd0));
        push(1'b0, 1'b0, OP_ADD, S(3'd5) | F_WE);
        push(1'b1, 1'b0, OP_LD,  S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, OP_LD,  S(3'd2));
        push(1'b0, 1'b0, OP_LD,  S(3'd3) | A(3'd0));
        push(1'b0, 1'b0, OP_LD,  S(3'd4) | F_RD);
        push(1'b0, 1'b0, OP_LD,  S(3'd4) | F_RD);
        push(1'b0, 1'b0, OP_LD,  S(3'd4) | F_RD);
        push(1'b1, 1'b0, OP_LD,  S(3'd4) | F_RD);
        push(1'b0, 1'b0, OP_LD,  S(3'd5) | F_WE);
        push(1'b1, 1'b1, OP_BRZ, S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b1, OP_BRZ, S(3'd2));
        push(1'b0, 1'b1, OP_BRZ, S(3'd3) | A(3'd1) | F_PCL);
        push(1'b1, 1'b0, OP_BRZ, S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, OP_BRZ, S(3'd2));
        push(1'b0, 1'b0, OP_BRZ, S(3'd3) | A(3'd1));
        push(1'b1, 1'b0, OP_JMP, S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, OP_JMP, S(3'd2) | F_PCL);
        push(1'b1, 1'b0, 6'h2A,  S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, 6'h2A,  S(3'd2) | F_ILL);
        push(1'b1, 1'b0, OP_OR,  S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, OP_OR,  S(3'd2));
        push(1'b0, 1'b0, OP_OR,  S(3'd3) | A(3'd3));
        push(1'b0, 1'b0, OP_OR,  S(3'd5) | F_WE);
        push(1'b1, 1'b0, OP_ST,  S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, OP_ST,  S(3'd2));
        push(1'b0, 1'b0, OP_ST,  S(3'd3) | A(3'd0));
        push(1'b1, 1'b0, OP_ST,  S(3'd4) | F_WR);
        push(1'b1, 1'b0, OP_NOP, S(3'd1) | F_RD | F_IRL | F_PCI);
        push(1'b0, 1'b0, OP_NOP, S(3'd2));
        run_q("table");

        // Fetch stuck: 15 wait cycles, bus_err on the 16th, then IDLE and a fresh FETCH
        for (int k = 0; k < TO; k++) step(1'b1, 1'b0, 1'b0, OP_ADD, S(3'd1) | F_RD, "fetch_wait");
        step(1'b1, 1'b0, 1'b0, OP_ADD, S(3'd1) | F_RD | F_BE, "fetch_timeout");
        step(1'b1, 1'b0, 1'b0, OP_ADD, S(3'd0), "timeout_idle");

        // HALT sticks until reset
        step(1'b1, 1'b1, 1'b0, OP_HLT, S(3'd1) | F_RD | F_IRL | F_PCI, "halt_fetch");
        step(1'b1, 1'b1, 1'b0, OP_HLT, S(3'd2), "halt_decode");
        for (int k = 0; k < 22; k++) step(1'b1, rb(), rb(), 6'($urandom_range(0, 63)), S(3'd6) | F_HL, "halted");
        step(1'b0, 1'b1, 1'b0, OP_HLT, S(3'd6) | F_HL, "halt_rst_edge");
        step(1'b1, 1'b0, 1'b0, OP_LD, S(3'd0), "halt_exit");

        // Reset while waiting in MEM
        step(1'b1, 1'b1, 1'b0, OP_LD, S(3'd1) | F_RD | F_IRL | F_PCI, "mem_rst_fetch");
        step(1'b1, 1'b0, 1'b0, OP_LD, S(3'd2), "mem_rst_decode");
        step(1'b1, 1'b0, 1'b0, OP_LD, S(3'd3) | A(3'd0), "mem_rst_exec");
        step(1'b1, 1'b0, 1'b0, OP_LD, S(3'd4) | F_RD, "mem_rst_wait");
        step(1'b0, 1'b0, 1'b0, OP_LD, S(3'd4) | F_RD, "mem_rst_edge");
        step(1'b1, 1'b0, 1'b0, OP_LD, S(3'd0), "mem_rst_idle");

        // Randomized instruction stream against the trace model
        for (int n = 0; n < 120; n++) gen(pick_op(), pick_wait(), pick_wait(), rb());
        run_q("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
